// File: rtl/activation_unit.sv
// Two-stage activation pipeline: S1 applies ReLU/leaky/linear shaping to each
// lane sum, S2 shifts, optionally rounds, clamps to the output width and counts
// saturations.
module activation_unit #(
  parameter int sumWidth  = 24,
  parameter int dataWidth = 8,
  parameter int lanes     = 4,
  parameter int fracShift = dataWidth - 1,
  parameter int leakShift = 3
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [lanes*sumWidth-1:0]    dataIn,
  input  logic [1:0]                   mode,
  input  logic                         roundEn,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [lanes*dataWidth-1:0]   dataOut,
  output logic [15:0]                  satCount,
  input  logic                         satClear
);

  localparam int SW  = sumWidth;
  localparam int EW  = sumWidth + 1;
  localparam int NSW = $clog2(lanes + 1);
  localparam int RND_SH = (fracShift > 0) ? fracShift - 1 : 0;

  localparam logic [1:0] MODE_RELU  = 2'd0;
  localparam logic [1:0] MODE_LEAKY = 2'd1;

  localparam logic signed [EW-1:0] RND_ONE = {{(EW-1){1'b0}}, 1'b1};
  localparam logic signed [EW-1:0] RND_VAL = (fracShift > 0) ? (RND_ONE <<< RND_SH) : '0;
  localparam logic signed [EW-1:0] MAXV =
    {{(EW-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [EW-1:0] MINV =
    {{(EW-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};

  // handshake
  logic w_s1_adv;
  logic w_s2_adv;
  logic w_out_fire;

  // stage 1 registers
  logic                   r_s1_valid;
  logic [lanes*SW-1:0]    r_s1_data;
  logic [1:0]             r_s1_mode;
  logic                   r_s1_round;

  // stage 2 registers
  logic                       r_s2_valid;
  logic [lanes*dataWidth-1:0] r_s2_data;
  logic [NSW-1:0]             r_s2_nsat;
  logic [15:0]                r_sat_count;

  // stage 1 combinational
  logic signed [SW-1:0]   w_x [lanes];
  logic signed [SW-1:0]   w_y [lanes];
  logic [lanes*SW-1:0]    w_s1_next;

  // stage 2 combinational
  logic signed [SW-1:0]   w_s1_lane [lanes];
  logic signed [EW-1:0]   w_ext     [lanes];
  logic signed [EW-1:0]   w_rnd;
  logic signed [EW-1:0]   w_sum     [lanes];
  logic signed [EW-1:0]   w_shr     [lanes];
  logic signed [EW-1:0]   w_lo;
  logic [dataWidth-1:0]   w_res     [lanes];
  logic [lanes*dataWidth-1:0] w_s2_next;
  logic [NSW-1:0]         w_nsat;

  logic [16:0]            w_cnt_sum;

  assign w_s2_adv   = !r_s2_valid || outReady;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_out_fire = r_s2_valid && outReady;

  assign inReady  = w_s1_adv;
  assign outValid = r_s2_valid;
  assign dataOut  = r_s2_data;
  assign satCount = r_sat_count;

  always_comb begin
    w_s1_next = '0;
    for (int i = 0; i < lanes; i++) begin
      w_x[i] = $signed(dataIn[i*SW +: SW]);
      w_y[i] = w_x[i];
      if (mode == MODE_RELU) begin
        if (w_x[i] < 0) w_y[i] = '0;
      end else if (mode == MODE_LEAKY) begin
        if (w_x[i] < 0) w_y[i] = w_x[i] >>> leakShift;
      end
      w_s1_next[i*SW +: SW] = w_y[i];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= 2'd0;
      r_s1_round <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= inValid;
      if (inValid) begin
        r_s1_data  <= w_s1_next;
        r_s1_mode  <= mode;
        r_s1_round <= roundEn;
      end
    end
  end

  // The sum is widened by one bit so the rounding add cannot wrap near the top.
  always_comb begin
    w_s2_next = '0;
    w_nsat    = '0;
    w_rnd     = r_s1_round ? RND_VAL : RND_ONE - RND_ONE;
    w_lo      = (r_s1_mode == MODE_RELU) ? RND_ONE - RND_ONE : MINV;
    for (int i = 0; i < lanes; i++) begin
      w_s1_lane[i] = $signed(r_s1_data[i*SW +: SW]);
      w_ext[i]     = {w_s1_lane[i][SW-1], w_s1_lane[i]};
      w_sum[i]     = w_ext[i] + w_rnd;
      w_shr[i]     = w_sum[i] >>> fracShift;
      if (w_shr[i] > MAXV) begin
        w_res[i] = MAXV[dataWidth-1:0];
        w_nsat   = w_nsat + NSW'(1);
      end else if (w_shr[i] < w_lo) begin
        w_res[i] = w_lo[dataWidth-1:0];
        w_nsat   = w_nsat + NSW'(1);
      end else begin
        w_res[i] = w_shr[i][dataWidth-1:0];
      end
      w_s2_next[i*dataWidth +: dataWidth] = w_res[i];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_nsat  <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_s2_next;
        r_s2_nsat <= w_nsat;
      end
    end
  end

  assign w_cnt_sum = {1'b0, r_sat_count} + 17'(r_s2_nsat);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_sat_count <= '0;
    end else if (satClear) begin
      r_sat_count <= '0;
    end else if (w_out_fire) begin
      r_sat_count <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
    end
  end

endmodule

// File: tb/tb_activation_unit.sv
// Directed bench for activation_unit at default parameters; inputs are driven
// and outputs sampled on the falling clock edge.
module tb_activation_unit;

  logic        clk;
  logic        resetN;
  logic        inValid;
  logic        inReady;
  logic [95:0] dataIn;
  logic [1:0]  mode;
  logic        roundEn;
  logic        outValid;
  logic        outReady;
  logic [31:0] dataOut;
  logic [15:0] satCount;
  logic        satClear;

  int total = 0;
  int bad   = 0;

  activation_unit dut (
    .clk      (clk),
    .resetN   (resetN),
    .inValid  (inValid),
    .inReady  (inReady),
    .dataIn   (dataIn),
    .mode     (mode),
    .roundEn  (roundEn),
    .outValid (outValid),
    .outReady (outReady),
    .dataOut  (dataOut),
    .satCount (satCount),
    .satClear (satClear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] pack4(input logic [23:0] l0, input logic [23:0] l1,
                                        input logic [23:0] l2, input logic [23:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [95:0] stream_word(input int k);
    logic [95:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w[j*24 +: 24] = 24'((k + 1 + j) * 128);
    return w;
  endfunction

  function automatic logic [31:0] stream_exp(input int k);
    logic [31:0] w;
    w = '0;
    for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'(k + 1 + j);
    return w;
  endfunction

  task automatic idle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [95:0] d, input logic [1:0] m, input logic r);
    inValid = 1'b1;
    dataIn  = d;
    mode    = m;
    roundEn = r;
    #1;
    check("push_ready", inReady, 1'b1);
    @(posedge clk);
    @(negedge clk);
    inValid = 1'b0;
  endtask

  logic [95:0] sat_word;
  logic [31:0] prev_data;
  int sent, recv, saw_block, have_prev;

  initial begin
    resetN   = 1'b0;
    inValid  = 1'b0;
    dataIn   = '0;
    mode     = 2'd0;
    roundEn  = 1'b0;
    outReady = 1'b1;
    satClear = 1'b0;
    sat_word = pack4(24'h7FFFFF, 24'h800000, 24'h010000, 24'hFF0000);

    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", outValid, 1'b0);
    check("rst_data_out", dataOut, 32'h0);
    check("rst_sat_count", satCount, 16'h0);
    resetN = 1'b1;
    #1;
    check("rst_in_ready", inReady, 1'b1);
    @(negedge clk);

    // ReLU: positive, saturating, negative-zeroed, zero
    push(pack4(24'h000380, 24'h008000, 24'hFFFF00, 24'h000000), 2'd0, 1'b0);
    check("relu_lat1_valid", outValid, 1'b0);
    idle();
    check("relu_valid", outValid, 1'b1);
    check("relu_data", dataOut, 32'h00007F07);
    check("relu_sat_pre", satCount, 16'd0);
    idle();
    check("relu_sat", satCount, 16'd1);
    check("relu_drained", outValid, 1'b0);

    // leaky then linear, back to back
    push(pack4(24'hFFFC00, 24'h0, 24'h0, 24'h0), 2'd1, 1'b0);
    push(pack4(24'hFF8000, 24'h0, 24'h0, 24'h0), 2'd2, 1'b0);
    check("leaky_data", dataOut, 32'h000000FF);
    idle();
    check("linear_neg_sat_data", dataOut, 32'h00000080);
    idle();
    check("linear_sat_count", satCount, 16'd2);

    // rounding on/off, then mode 3 behaving as linear
    push(pack4(24'h0000C0, 24'h0, 24'h0, 24'h0), 2'd2, 1'b1);
    push(pack4(24'h0000C0, 24'h0, 24'h0, 24'h0), 2'd2, 1'b0);
    check("round_on", dataOut, 32'h00000002);
    push(pack4(24'hFFFF00, 24'h0, 24'h0, 24'h0), 2'd3, 1'b0);
    check("round_off", dataOut, 32'h00000001);
    idle();
    check("mode3_linear", dataOut, 32'h000000FE);
    idle();
    check("no_sat_added", satCount, 16'd2);

    satClear = 1'b1;
    idle();
    satClear = 1'b0;
    check("sat_clear", satCount, 16'd0);

    // streaming with backpressure during loop cycles 3..7
    sent = 0; recv = 0; saw_block = 0; have_prev = 0; prev_data = '0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      inValid  = (sent < 8);
      dataIn   = stream_word(sent);
      mode     = 2'd2;
      roundEn  = 1'b0;
      outReady = !(c >= 3 && c <= 7);
      #1;
      if (!inReady) saw_block = 1;
      if (have_prev != 0) begin
        check("stall_hold", dataOut, prev_data);
        have_prev = 0;
      end
      if (outValid && outReady) begin
        check("stream_order", dataOut, stream_exp(recv));
        recv++;
      end
      if (outValid && !outReady) begin
        prev_data = dataOut;
        have_prev = 1;
      end
      if (inValid && inReady) sent++;
      @(posedge clk);
      @(negedge clk);
    end
    inValid  = 1'b0;
    outReady = 1'b1;
    check("stream_count", recv, 8);
    check("stream_sent", sent, 8);
    check("stream_in_ready_dropped", saw_block, 1);
    idle();
    check("stream_drained", outValid, 1'b0);
    check("stream_no_sat", satCount, 16'd0);

    // all four lanes saturating, with rounding near the top of the range
    push(sat_word, 2'd2, 1'b1);
    idle();
    check("sat4_data", dataOut, 32'h807F807F);
    idle();
    check("sat4_count", satCount, 16'd4);

    inValid = 1'b1; dataIn = sat_word; mode = 2'd2; roundEn = 1'b1;
    repeat (300) @(negedge clk);
    inValid = 1'b0;
    repeat (3) idle();
    check("sat_300_beats", satCount, 16'd1204);

    inValid = 1'b1;
    repeat (16100) @(negedge clk);
    inValid = 1'b0;
    repeat (3) idle();
    check("sat_sticky", satCount, 16'hFFFF);
    push(sat_word, 2'd2, 1'b0);
    repeat (2) idle();
    check("sat_hold", satCount, 16'hFFFF);

    // clear coinciding with a saturating output transfer
    push(sat_word, 2'd2, 1'b0);
    idle();
    check("clr_race_valid", outValid, 1'b1);
    satClear = 1'b1;
    idle();
    satClear = 1'b0;
    check("clr_priority", satCount, 16'd0);
    check("clr_race_drained", outValid, 1'b0);
    push(sat_word, 2'd2, 1'b0);
    repeat (2) idle();
    check("count_after_clear", satCount, 16'd4);

    // reset with two beats in flight
    push(sat_word, 2'd2, 1'b0);
    push(pack4(24'h000100, 24'h0, 24'h0, 24'h0), 2'd2, 1'b0);
    resetN = 1'b0;
    #1;
    check("midrst_out_valid", outValid, 1'b0);
    check("midrst_sat_count", satCount, 16'd0);
    check("midrst_data_out", dataOut, 32'h0);
    @(negedge clk);
    resetN = 1'b1;
    push(pack4(24'h000280, 24'h0, 24'h0, 24'h0), 2'd2, 1'b0);
    check("midrst_no_stale", outValid, 1'b0);
    idle();
    check("midrst_first_valid", outValid, 1'b1);
    check("midrst_first_data", dataOut, 32'h00000005);
    idle();
    check("midrst_done", outValid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
